// File: rtl/nxm_queue_pkg.sv
// Shared types and width helpers for the nxm_queue circular FIFO.
package nxm_queue_pkg;

  // Occupancy state, derived from the occupancy count.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Pointer width for a mod-depth pointer (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width able to represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nxm_queue_ptr.sv
// Mod-DEPTH wrapping pointer; steps by one whenever advance is high.
module nxm_queue_ptr
  import nxm_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_r;

  // Pointer register: clear on reset, wrap from DEPTH-1 back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {PW{1'b0}};
    end else if (advance) begin
      if (ptr_r == PW'(DEPTH - 1)) begin
        ptr_r <= {PW{1'b0}};
      end else begin
        ptr_r <= ptr_r + PW'(1'b1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/nxm_queue.sv
// Circular FIFO with registered head output, peek (front), sticky
// overflow/underflow flags and an EMPTY/PARTIAL/FULL occupancy FSM.
module nxm_queue
  import nxm_queue_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int QUEUESIZE = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              push,
  input  logic                              pop,
  input  logic                              front,
  input  logic [BITWIDTH-1:0]               data_in,
  output logic [BITWIDTH-1:0]               data_out,
  output logic                              queue_overflow,
  output logic                              queue_underflow,
  output logic                              queue_is_empty,
  output logic                              queue_is_full,
  output logic [cnt_width(QUEUESIZE)-1:0]   count
);

  localparam int PW = ptr_width(QUEUESIZE);
  localparam int CW = cnt_width(QUEUESIZE);

  occ_e                occ_r;
  occ_e                occ_nxt_s;
  logic [CW-1:0]       count_r;
  logic [CW-1:0]       count_nxt_s;
  logic [PW-1:0]       head_s;
  logic [PW-1:0]       tail_s;
  logic [BITWIDTH-1:0] mem_r [QUEUESIZE];
  logic [BITWIDTH-1:0] data_out_r;
  logic                overflow_r;
  logic                underflow_r;
  logic                empty_r;
  logic                full_r;
  logic                do_push_s;
  logic                do_pop_s;
  logic                do_front_s;
  logic                set_ovf_s;
  logic                set_udf_s;

  nxm_queue_ptr #(.DEPTH(QUEUESIZE)) u_head (
    .clk     (clk),
    .rst     (rst),
    .advance (do_pop_s),
    .ptr     (head_s)
  );

  nxm_queue_ptr #(.DEPTH(QUEUESIZE)) u_tail (
    .clk     (clk),
    .rst     (rst),
    .advance (do_push_s),
    .ptr     (tail_s)
  );

  // Operation decode from the current occupancy state and requests.
  always_comb begin
    do_push_s  = 1'b0;
    do_pop_s   = 1'b0;
    do_front_s = 1'b0;
    set_ovf_s  = 1'b0;
    set_udf_s  = 1'b0;
    if (enable) begin
      case (occ_r)
        OCC_EMPTY: begin
          // A pop on an empty queue is an underflow even if push stores.
          do_push_s = push;
          set_udf_s = pop;
        end
        OCC_PARTIAL: begin
          do_push_s  = push;
          do_pop_s   = pop;
          do_front_s = front & ~pop;
        end
        OCC_FULL: begin
          // Simultaneous pop frees the slot, so the push is accepted.
          do_push_s  = push & pop;
          do_pop_s   = pop;
          do_front_s = front & ~pop;
          set_ovf_s  = push & ~pop;
        end
        default: begin
          do_push_s = 1'b0;
        end
      endcase
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Next occupancy count and the state derived from it.
  always_comb begin
    count_nxt_s = count_r;
    occ_nxt_s   = occ_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + CW'(1'b1);
    end else if (!do_push_s && do_pop_s) begin
      count_nxt_s = count_r - CW'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end
    if (count_nxt_s == {CW{1'b0}}) begin
      occ_nxt_s = OCC_EMPTY;
    end else if (count_nxt_s == CW'(QUEUESIZE)) begin
      occ_nxt_s = OCC_FULL;
    end else begin
      occ_nxt_s = OCC_PARTIAL;
    end
  end

  // State register: occupancy, count and the registered empty/full flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r   <= OCC_EMPTY;
      count_r <= {CW{1'b0}};
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      occ_r   <= occ_nxt_s;
      count_r <= count_nxt_s;
      empty_r <= (occ_nxt_s == OCC_EMPTY);
      full_r  <= (occ_nxt_s == OCC_FULL);
    end
  end

  // Head output register and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r  <= {BITWIDTH{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (do_pop_s || do_front_s) begin
        data_out_r <= mem_r[head_s];
      end else begin
        data_out_r <= data_out_r;
      end
      overflow_r  <= overflow_r | set_ovf_s;
      underflow_r <= underflow_r | set_udf_s;
    end
  end

  // Storage array; intentionally not reset, stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[tail_s] <= data_in;
    end
  end

  assign data_out        = data_out_r;
  assign queue_overflow  = overflow_r;
  assign queue_underflow = underflow_r;
  assign queue_is_empty  = empty_r;
  assign queue_is_full   = full_r;
  assign count           = count_r;

endmodule

// File: tb/tb_nxm_queue.sv
// Directed bench for nxm_queue (BITWIDTH=3, QUEUESIZE=5) with a queue
// scoreboard: each step pushes its expected outputs, popped after the edge.
module tb_nxm_queue;

  localparam int BW = 3;
  localparam int QS = 5;
  localparam int CW = $clog2(QS + 1);

  typedef struct {
    logic [BW-1:0] dout;
    int            cnt;
    logic          ovf;
    logic          udf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          push;
  logic          pop;
  logic          front;
  logic [BW-1:0] data_in;
  logic [BW-1:0] data_out;
  logic          queue_overflow;
  logic          queue_underflow;
  logic          queue_is_empty;
  logic          queue_is_full;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [BW-1:0] model_q[$];
  logic [BW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;
  exp_t          sb_q[$];

  nxm_queue #(.BITWIDTH(BW), .QUEUESIZE(QS)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .push            (push),
    .pop             (pop),
    .front           (front),
    .data_in         (data_in),
    .data_out        (data_out),
    .queue_overflow  (queue_overflow),
    .queue_underflow (queue_underflow),
    .queue_is_empty  (queue_is_empty),
    .queue_is_full   (queue_is_full),
    .count           (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle, update the model, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic en,
                      input logic pu, input logic po, input logic fr,
                      input logic [BW-1:0] din);
    exp_t e;
    bit   was_full;
    bit   was_empty;
    rst = r; enable = en; push = pu; pop = po; front = fr; data_in = din;
    if (r) begin
      model_q.delete();
      m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (en) begin
      was_full  = (model_q.size() == QS);
      was_empty = (model_q.size() == 0);
      if (po && !was_empty) m_dout = model_q.pop_front();
      else if (fr && !po && !was_empty) m_dout = model_q[0];
      if (pu && (!was_full || po)) model_q.push_back(din);
      if (pu && was_full && !po) m_ovf = 1'b1;
      if (po && was_empty) m_udf = 1'b1;
    end
    e.dout = m_dout; e.cnt = model_q.size(); e.ovf = m_ovf; e.udf = m_udf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".data_out"}, 32'(data_out), 32'(e.dout));
    check({tag, ".count"}, 32'(count), 32'(e.cnt));
    check({tag, ".empty"}, 32'(queue_is_empty), 32'(e.cnt == 0));
    check({tag, ".full"}, 32'(queue_is_full), 32'(e.cnt == QS));
    check({tag, ".ovf"}, 32'(queue_overflow), 32'(e.ovf));
    check({tag, ".udf"}, 32'(queue_underflow), 32'(e.udf));
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; push = 1'b0; pop = 1'b0; front = 1'b0; data_in = '0;
    model_q.delete();
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;

    // Reset then idle.
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    step("idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    check("idle.dout_const", 32'(data_out), 32'd0);

    // Push 0..7: fills at the 5th, overflow from the 6th.
    for (int i = 0; i < 8; i++) begin
      step("fill", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i));
      if (i == 4) check("fill.full_at5", 32'(queue_is_full), 32'd1);
      if (i == 5) check("fill.ovf_at6", 32'(queue_overflow), 32'd1);
    end

    // Alternate front/pop six times: 0,0,1,1,...,4,4 then underflow.
    for (int i = 0; i < 6; i++) begin
      step("front", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
      step("pop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      if (i < 5) check("pop.const", 32'(data_out), 32'(i));
    end
    check("udf.dout_held", 32'(data_out), 32'd4);
    check("udf.flag", 32'(queue_underflow), 32'd1);
    check("udf.empty", 32'(queue_is_empty), 32'd1);

    // Wrap test.
    step("rst2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 1; i <= 3; i++) step("w.push", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i));
    step("w.pop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    step("w.pop", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    check("w.pop2_const", 32'(data_out), 32'd2);
    for (int i = 4; i <= 7; i++) step("w.push", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i));
    for (int i = 3; i <= 7; i++) begin
      step("w.drain", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
      check("w.drain_const", 32'(data_out), 32'(i));
    end

    // Full with simultaneous push+pop.
    for (int i = 0; i < 5; i++) step("f.push", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'(i + 1));
    step("f.pushpop", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd6);
    check("f.pushpop_head", 32'(data_out), 32'd1);
    check("f.pushpop_cnt", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) step("f.drain", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    check("f.tail6", 32'(data_out), 32'd6);

    // Front combined with push and with pop.
    step("c.push", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3);
    step("c.pushfront", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5);
    step("c.popfront", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);

    // Enable low holds everything.
    step("en0.push", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7);
    check("en0.cnt", 32'(count), 32'd1);

    // Reset while partial, then push+pop on empty.
    step("p.push", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    step("rst3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    check("rst3.cnt", 32'(count), 32'd0);
    step("e.pushpop", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4);
    check("e.pushpop_cnt", 32'(count), 32'd1);
    step("e.front", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0);
    check("e.front_val", 32'(data_out), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nxm_queue.md
NXM_QUEUE -- requirements
Module: nxm_queue

Interface
REQ-001 SHALL have parameter BITWIDTH, default 8: data word width.
REQ-002 SHALL have parameter QUEUESIZE, default 8: entry depth (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  when 0, all state holds.
REQ-006 SHALL have port push  input  1  enqueue data_in at tail.
REQ-007 SHALL have port pop  input  1  dequeue head into data_out.
REQ-008 SHALL have port front  input  1  copy head to data_out without dequeue.
REQ-009 SHALL have port data_in  input  BITWIDTH  enqueue data.
REQ-010 SHALL have port data_out  output  BITWIDTH  registered head value.
REQ-011 SHALL have port queue_overflow  output  1  sticky: push attempted while full.
REQ-012 SHALL have port queue_underflow  output  1  sticky: pop attempted while empty.
REQ-013 SHALL have port queue_is_empty  output  1  count==0.
REQ-014 SHALL have port queue_is_full  output  1  count==QUEUESIZE.
REQ-015 SHALL have port count  output  $clog2(QUEUESIZE+1)  current occupancy.

Function
REQ-016 The block SHALL be a circular FIFO: a write goes to the tail, a read comes from the head, and each pointer wraps from QUEUESIZE-1 to 0.
REQ-017 Occupancy state SHALL be EMPTY, PARTIAL or FULL, derived from count and updated on the same edge as count.
REQ-018 With enable=0 and rst=0, pointers, count, data_out and flags SHALL hold.
REQ-019 A push when not full SHALL write data_in at the tail, advance the tail and increment count.
REQ-020 A push when full without pop SHALL drop data_in, leave state unchanged and set queue_overflow.
REQ-021 A pop when not empty SHALL load the head entry into data_out on that edge (1-cycle latency), advance the head and decrement count.
REQ-022 A pop when empty SHALL hold data_out and pointers and set queue_underflow.
REQ-023 A front when not empty SHALL load the head entry into data_out with no pointer or count change.
REQ-024 A front when empty SHALL be a no-op with no flag set.
REQ-025 Push+pop while PARTIAL or FULL SHALL perform both operations; count SHALL be unchanged and overflow SHALL NOT be set.
REQ-026 Push+pop while EMPTY SHALL store the push (count becomes 1), treat the pop as underflow and hold data_out.
REQ-027 Pop together with front SHALL behave as pop alone; push together with front SHALL perform both.
REQ-028 queue_is_empty, queue_is_full and count SHALL be driven from registers with no combinational path from the inputs.
REQ-029 queue_overflow and queue_underflow SHALL stay set until rst.

Reset
REQ-030 With rst=1 on a rising edge, the block SHALL clear head, tail, count, data_out, queue_overflow and queue_underflow to 0 and set queue_is_empty=1, regardless of enable.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 A reset mid-operation SHALL discard all queued entries; the first operation after reset SHALL see the queue EMPTY.

Structure
REQ-033 Package nxm_queue_pkg SHALL hold the occupancy-state enum (EMPTY/PARTIAL/FULL) and the pointer/count width helper functions.
REQ-034 Sub-module nxm_queue_ptr (mod-QUEUESIZE wrapping pointer with advance input) SHALL be instantiated twice, for head and tail.

Verification (BITWIDTH=3, QUEUESIZE=5)
REQ-035 Reset, then idle -> data_out=0, count=0, queue_is_empty=1, both sticky flags 0.
REQ-036 Push 0..7 on consecutive cycles -> count=5 and queue_is_full=1 after the 5th push; queue_overflow=1 after the 6th push; values 5, 6 and 7 are dropped.
REQ-037 Alternate front/pop six times -> data_out shows 0,0,1,1,2,2,3,3,4,4; the 6th pop sets queue_underflow=1 with data_out holding 4 and queue_is_empty=1.
REQ-038 Wrap test: push 1,2,3, pop twice, push 4,5,6,7 -> pops return 1,2, then subsequent pops return 3,4,5,6,7 in order across the pointer wrap.
REQ-039 With the queue full, assert push=1 (data_in=6) and pop=1 in the same cycle -> count stays 5, no overflow, the old head is output, and 6 is appended at the tail.
REQ-040 With enable=0, assert push -> no change; asserting rst while PARTIAL -> count=0 and queue_is_empty=1 on the next edge.
